// File: rtl/call_return_stack.sv
// Return-address stack for the 19-bit CPU.
// A CALL pushes the return address. A RET pops it, and the RET target
// (ret_addr) is visible combinationally in the cycle the RET is decoded.
// Overflow and underflow are sticky until clr_err is seen on an unstalled cycle.
module call_return_stack #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] ret_in,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] ret_addr,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage is indexed directly by the occupancy count, so there is
    // no circular wrap.
    logic [ADDR_W-1:0] entry_q [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  top_idx;

    // Occupancy decode and the top-of-stack index.
    // When the stack is full, the low bits of count wrap to 0.
    // top_idx then wraps to DEPTH-1, which is the correct top entry.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        push_idx = count_q[IDX_W-1:0];
        top_idx  = push_idx - IDX_W'(1);
    end

    // RET target: the top entry when the stack holds data, otherwise zero.
    always_comb begin
        ret_addr = empty ? '0 : entry_q[top_idx];
    end

    // Next-state decision for count, flags and the entry write.
    always_comb begin
        // NOTE: every output of this block gets a default first. This means
        // no path leaves a value unassigned, so no latch is inferred.
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_idx      = push_idx;

        if (!stall) begin
            // The clear is applied first, so an error later in this block
            // overrides it.
            if (clr_err) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end

            if (call && !ret) begin
                if (!full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (ret && !call) begin
                if (!empty) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end else if (call && ret) begin
                wr_en = 1'b1;
                if (!empty) begin
                    // Return and call in one cycle replace the top entry.
                    wr_idx = top_idx;
                end else begin
                    // On an empty stack, this behaves as a push and flags
                    // the missing pop.
                    wr_idx      = '0;
                    count_d     = CNT_W'(1);
                    underflow_d = 1'b1;
                end
            end
        end
    end

    // Control state: count and sticky flags, cleared by async reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment. All flops then
        // sample their inputs before any of them change.
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry write port. Entries at or above count are never read.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. Stale contents are invisible,
        // and leaving out the reset lets this map onto plain RAM/register-file cells.
        if (wr_en && !rst) begin
            entry_q[wr_idx] <= ret_in;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_call_return_stack.sv
// Directed bench for call_return_stack.
// Expected values are queued as stimulus is driven, then popped and compared
// against the sampled outputs.
module tb_call_return_stack;

    localparam int ADDR_W = 19;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 5;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] ret_in;
    logic              clr_err;
    logic [ADDR_W-1:0] ret_addr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    typedef enum int {F_COUNT, F_ADDR, F_EMPTY, F_FULL, F_OVF, F_UNF} field_e;

    typedef struct {
        string       tag;
        field_e      f;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    call_return_stack #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .call     (call),
        .ret      (ret),
        .ret_in   (ret_in),
        .clr_err  (clr_err),
        .ret_addr (ret_addr),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(field_e f);
        case (f)
            F_COUNT: return 32'(count);
            F_ADDR:  return 32'(ret_addr);
            F_EMPTY: return 32'(empty);
            F_FULL:  return 32'(full);
            F_OVF:   return 32'(overflow);
            default: return 32'(underflow);
        endcase
    endfunction

    task automatic want(input string tag, input field_e f, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.f   = f;
        e.val = v;
        sb.push_back(e);
    endtask

    // Pop every queued expectation and compare it with the current outputs.
    task automatic check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.f);
            n_checks++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive one cycle's inputs just after a falling edge.
    task automatic drive(input logic st, input logic c, input logic r,
                         input logic [ADDR_W-1:0] d, input logic clr);
        @(negedge clk);
        stall   = st;
        call    = c;
        ret     = r;
        ret_in  = d;
        clr_err = clr;
    endtask

    // Let the rising edge take the inputs, then return to idle and settle.
    task automatic tick();
        @(posedge clk);
        #1;
        stall   = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        ret_in  = '0;
        clr_err = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] d);
        drive(1'b0, 1'b1, 1'b0, d, 1'b0);
        tick();
    endtask

    task automatic pop();
        drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        stall    = 1'b0;
        call     = 1'b0;
        ret      = 1'b0;
        ret_in   = '0;
        clr_err  = 1'b0;
        #12;
        rst = 1'b0;

        // Reset state.
        #1;
        want("rst_count", F_COUNT, 0);
        want("rst_empty", F_EMPTY, 1);
        want("rst_full",  F_FULL,  0);
        want("rst_ovf",   F_OVF,   0);
        want("rst_unf",   F_UNF,   0);
        want("rst_addr",  F_ADDR,  0);
        check();

        // 1: single push.
        push(19'h00ABC);
        want("t1_count", F_COUNT, 1);
        want("t1_empty", F_EMPTY, 0);
        want("t1_addr",  F_ADDR,  32'h00ABC);
        want("t1_ovf",   F_OVF,   0);
        want("t1_unf",   F_UNF,   0);
        check();
        pop();
        want("t1_drain", F_COUNT, 0);
        check();

        // 2: LIFO order. The RET target is checked in the RET cycle itself.
        push(19'h10);
        push(19'h20);
        push(19'h30);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
            #1;
            want("t2_ret_addr", F_ADDR, 32'h30 - 32'(i) * 32'h10);
            check();
            tick();
        end
        want("t2_count", F_COUNT, 0);
        want("t2_empty", F_EMPTY, 1);
        want("t2_addr",  F_ADDR,  0);
        check();

        // 3: fill the stack, then overflow it.
        for (int i = 1; i <= DEPTH; i++) push(ADDR_W'(i));
        want("t3_full",       F_FULL,  1);
        want("t3_count_full", F_COUNT, DEPTH);
        check();
        push(19'h7FFFF);
        want("t3_count_ovf", F_COUNT, DEPTH);
        want("t3_addr_ovf",  F_ADDR,  DEPTH);
        want("t3_ovf",       F_OVF,   1);
        check();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
        want("t3_ovf_clr",   F_OVF,   0);
        want("t3_count_clr", F_COUNT, DEPTH);
        check();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0, 1'b0);
            #1;
            want("t3_drain_addr", F_ADDR, 32'(DEPTH - i));
            check();
            tick();
        end
        want("t3_drained", F_EMPTY, 1);
        check();

        // 4: underflow, then a clear that collides with a new underflow.
        pop();
        want("t4_unf",   F_UNF,   1);
        want("t4_count", F_COUNT, 0);
        check();
        drive(1'b0, 1'b0, 1'b1, '0, 1'b1);
        tick();
        want("t4_unf_wins", F_UNF, 1);
        check();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        tick();
        want("t4_unf_clr", F_UNF, 0);
        check();

        // 5: simultaneous call and ret.
        push(19'h10);
        push(19'h20);
        drive(1'b0, 1'b1, 1'b1, 19'h55, 1'b0);
        tick();
        want("t5_count_rep", F_COUNT, 2);
        want("t5_addr_rep",  F_ADDR,  32'h55);
        want("t5_unf_rep",   F_UNF,   0);
        want("t5_ovf_rep",   F_OVF,   0);
        check();
        pop();
        want("t5_addr_after", F_ADDR,  32'h10);
        want("t5_count_after", F_COUNT, 1);
        check();
        pop();
        drive(1'b0, 1'b1, 1'b1, 19'h66, 1'b0);
        tick();
        want("t5_count_empty", F_COUNT, 1);
        want("t5_addr_empty",  F_ADDR,  32'h66);
        want("t5_unf_empty",   F_UNF,   1);
        check();
        drive(1'b0, 1'b0, 1'b1, '0, 1'b1);
        tick();
        want("t5_cleanup", F_COUNT, 0);
        want("t5_unf_cleared", F_UNF, 0);
        check();

        // 6: stall holds everything, including clr_err; then an async reset.
        pop();
        push(19'h0A);
        push(19'h0B);
        push(19'h0C);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 19'h77, 1'b1);
            tick();
        end
        want("t6_stall_count", F_COUNT, 3);
        want("t6_stall_addr",  F_ADDR,  32'h0C);
        want("t6_stall_unf",   F_UNF,   1);
        check();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        want("t6_rst_count", F_COUNT, 0);
        want("t6_rst_addr",  F_ADDR,  0);
        want("t6_rst_unf",   F_UNF,   0);
        want("t6_rst_ovf",   F_OVF,   0);
        want("t6_rst_empty", F_EMPTY, 1);
        check();
        #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
